// File: rtl/rv32i_ex_mem_reg.sv
// +------------------------------------------------------------------------+
// | rv32i_ex_mem_reg : EX->MEM pipeline register with load/store decode,   |
// |                    illegal-encoding flag and load/store event counters |
// | Revision 1.0                                                           |
// +------------------------------------------------------------------------+
`default_nettype none

module rv32i_ex_mem_reg #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             flush,
  input  logic             ex_valid,
  input  logic [31:0]      ex_alu_res,
  input  logic [31:0]      ex_rs2_data,
  input  logic [2:0]       ex_funct3,
  input  logic             ex_is_load,
  input  logic             ex_is_store,
  input  logic [4:0]       ex_rd,
  input  logic             ex_reg_we,
  input  logic [31:0]      ex_pc,
  output logic             mem_valid,
  output logic [31:0]      dm_adr,
  output logic [1:0]       access_sz,
  output logic             s_us,
  output logic [31:0]      sd_32,
  output logic [1:0]       acc_type,
  output logic [4:0]       mem_rd,
  output logic             mem_reg_we,
  output logic             mem_wb_sel,
  output logic [31:0]      mem_pc,
  output logic             illegal_mem,
  output logic [CNT_W-1:0] ld_cnt,
  output logic [CNT_W-1:0] st_cnt
);

  localparam logic [1:0] c_ACC_NONE  = 2'b00;
  localparam logic [1:0] c_ACC_READ  = 2'b01;
  localparam logic [1:0] c_ACC_WRITE = 2'b10;

  logic       w_ld_f3_ok;
  logic       w_st_f3_ok;
  logic       w_illegal;
  logic       w_load;
  logic       w_store;
  logic [1:0] w_acc_type;
  logic [1:0] w_access_sz;
  logic       w_s_us;
  logic       w_wb_sel;
  logic       w_reg_we;

  always_comb begin
    w_ld_f3_ok = 1'b0;
    w_st_f3_ok = 1'b0;
    case (ex_funct3)
      3'b000, 3'b001, 3'b010: begin
        w_ld_f3_ok = 1'b1;
        w_st_f3_ok = 1'b1;
      end
      3'b100, 3'b101: w_ld_f3_ok = 1'b1;
      default: begin
        w_ld_f3_ok = 1'b0;
        w_st_f3_ok = 1'b0;
      end
    endcase
  end

  // Bubbles never raise the illegal flag; only a real instruction can trap.
  always_comb begin
    w_illegal = ex_valid & ((ex_is_load & ex_is_store) |
                            (ex_is_load & ~w_ld_f3_ok) |
                            (ex_is_store & ~w_st_f3_ok));
    w_load    = ex_valid & ex_is_load  & ~ex_is_store & w_ld_f3_ok;
    w_store   = ex_valid & ex_is_store & ~ex_is_load  & w_st_f3_ok;

    w_acc_type = c_ACC_NONE;
    if (w_load) begin
      w_acc_type = c_ACC_READ;
    end else if (w_store) begin
      w_acc_type = c_ACC_WRITE;
    end

    // funct3[1:0] is the size code for every legal access; bit 2 marks unsigned loads.
    w_access_sz = (w_load | w_store) ? ex_funct3[1:0] : 2'b00;
    w_s_us      = w_load & ex_funct3[2];
    w_wb_sel    = w_load;
    w_reg_we    = ex_valid & ~w_illegal & ~w_store & ex_reg_we;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_valid   <= 1'b0;
      dm_adr      <= 32'd0;
      access_sz   <= 2'b00;
      s_us        <= 1'b0;
      sd_32       <= 32'd0;
      acc_type    <= c_ACC_NONE;
      mem_rd      <= 5'd0;
      mem_reg_we  <= 1'b0;
      mem_wb_sel  <= 1'b0;
      mem_pc      <= 32'd0;
      illegal_mem <= 1'b0;
      ld_cnt      <= '0;
      st_cnt      <= '0;
    end else if (flush) begin
      mem_valid   <= 1'b0;
      dm_adr      <= 32'd0;
      access_sz   <= 2'b00;
      s_us        <= 1'b0;
      sd_32       <= 32'd0;
      acc_type    <= c_ACC_NONE;
      mem_rd      <= 5'd0;
      mem_reg_we  <= 1'b0;
      mem_wb_sel  <= 1'b0;
      mem_pc      <= 32'd0;
      illegal_mem <= 1'b0;
    end else if (!stall) begin
      mem_valid   <= ex_valid;
      dm_adr      <= ex_alu_res;
      access_sz   <= w_access_sz;
      s_us        <= w_s_us;
      sd_32       <= ex_rs2_data;
      acc_type    <= w_acc_type;
      mem_rd      <= ex_rd;
      mem_reg_we  <= w_reg_we;
      mem_wb_sel  <= w_wb_sel;
      mem_pc      <= ex_pc;
      illegal_mem <= w_illegal;
      if (w_load) begin
        ld_cnt <= ld_cnt + CNT_W'(1);
      end
      if (w_store) begin
        st_cnt <= st_cnt + CNT_W'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rv32i_ex_mem_reg.sv
// Randomised and directed scoreboard bench for rv32i_ex_mem_reg against a rule-level model.
`default_nettype none

module tb_rv32i_ex_mem_reg;

  localparam int CW = 2;

  typedef struct packed {
    logic          valid;
    logic [31:0]   adr;
    logic [1:0]    sz;
    logic          us;
    logic [31:0]   sd;
    logic [1:0]    acc;
    logic [4:0]    rd;
    logic          we;
    logic          wb;
    logic [31:0]   pc;
    logic          ill;
    logic [CW-1:0] ldc;
    logic [CW-1:0] stc;
  } out_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic stall = 1'b0, flush = 1'b0, ex_valid = 1'b0;
  logic [31:0] ex_alu_res = '0, ex_rs2_data = '0, ex_pc = '0;
  logic [2:0]  ex_funct3 = '0;
  logic        ex_is_load = 1'b0, ex_is_store = 1'b0, ex_reg_we = 1'b0;
  logic [4:0]  ex_rd = '0;

  logic          mem_valid, s_us, mem_reg_we, mem_wb_sel, illegal_mem;
  logic [31:0]   dm_adr, sd_32, mem_pc;
  logic [1:0]    access_sz, acc_type;
  logic [4:0]    mem_rd;
  logic [CW-1:0] ld_cnt, st_cnt;

  rv32i_ex_mem_reg #(.CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .ex_valid(ex_valid), .ex_alu_res(ex_alu_res), .ex_rs2_data(ex_rs2_data),
    .ex_funct3(ex_funct3), .ex_is_load(ex_is_load), .ex_is_store(ex_is_store),
    .ex_rd(ex_rd), .ex_reg_we(ex_reg_we), .ex_pc(ex_pc),
    .mem_valid(mem_valid), .dm_adr(dm_adr), .access_sz(access_sz), .s_us(s_us),
    .sd_32(sd_32), .acc_type(acc_type), .mem_rd(mem_rd), .mem_reg_we(mem_reg_we),
    .mem_wb_sel(mem_wb_sel), .mem_pc(mem_pc), .illegal_mem(illegal_mem),
    .ld_cnt(ld_cnt), .st_cnt(st_cnt)
  );

  always #5 clk = ~clk;

  out_t act;
  assign act = '{mem_valid, dm_adr, access_sz, s_us, sd_32, acc_type, mem_rd,
                 mem_reg_we, mem_wb_sel, mem_pc, illegal_mem, ld_cnt, st_cnt};

  out_t model = '0;
  out_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;

  task automatic check(input string name, input out_t got, input out_t exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t: got %h expected %h", name, $time, got, exp);
    end
  endtask

  // Reference behaviour stated as instruction-class rules, not as register logic.
  function automatic out_t predict(input out_t prev);
    out_t n;
    bit   is_ld_ok, is_st_ok;
    if (flush) begin
      n = '0;
      n.ldc = prev.ldc;
      n.stc = prev.stc;
      return n;
    end
    if (stall) return prev;
    n       = '0;
    n.ldc   = prev.ldc;
    n.stc   = prev.stc;
    n.valid = ex_valid;
    n.adr   = ex_alu_res;
    n.sd    = ex_rs2_data;
    n.rd    = ex_rd;
    n.pc    = ex_pc;
    if (!ex_valid) return n;
    is_ld_ok = ex_funct3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    is_st_ok = ex_funct3 inside {3'd0, 3'd1, 3'd2};
    if ((ex_is_load && ex_is_store) || (ex_is_load && !is_ld_ok) || (ex_is_store && !is_st_ok)) begin
      n.ill = 1'b1;
    end else if (ex_is_load) begin
      case (ex_funct3)
        3'd0: begin n.sz = 2'd0; n.us = 1'b0; end
        3'd1: begin n.sz = 2'd1; n.us = 1'b0; end
        3'd2: begin n.sz = 2'd2; n.us = 1'b0; end
        3'd4: begin n.sz = 2'd0; n.us = 1'b1; end
        default: begin n.sz = 2'd1; n.us = 1'b1; end
      endcase
      n.acc = 2'b01;
      n.wb  = 1'b1;
      n.we  = ex_reg_we;
      n.ldc = CW'((int'(prev.ldc) + 1) % (1 << CW));
    end else if (ex_is_store) begin
      n.sz  = (ex_funct3 == 3'd0) ? 2'd0 : (ex_funct3 == 3'd1) ? 2'd1 : 2'd2;
      n.acc = 2'b10;
      n.stc = CW'((int'(prev.stc) + 1) % (1 << CW));
    end else begin
      n.we = ex_reg_we;
    end
    return n;
  endfunction

  task automatic drive(input logic v, ld, st, input logic [2:0] f3,
                       input logic [31:0] alu, rs2, input logic [4:0] rd,
                       input logic we, input logic [31:0] pc, input logic stl, fl);
    @(negedge clk);
    ex_valid = v; ex_is_load = ld; ex_is_store = st; ex_funct3 = f3;
    ex_alu_res = alu; ex_rs2_data = rs2; ex_rd = rd; ex_reg_we = we; ex_pc = pc;
    stall = stl; flush = fl;
    model = predict(model);
    sb.push_back(model);
  endtask

  // Asynchronous reset: checked with no clock edge, then held across one edge.
  task automatic do_reset();
    @(negedge clk);
    ex_valid = 1'b1; ex_is_load = 1'b1; ex_funct3 = 3'd2; ex_alu_res = $urandom | 32'h1;
    ex_rs2_data = $urandom | 32'h1; ex_rd = 5'd7; ex_reg_we = 1'b1; ex_pc = $urandom | 32'h1;
    rst_n = 1'b0;
    model = '0;
    #1 check("reset_async", act, model);
    @(posedge clk);
    #2 check("reset_held", act, model);
    rst_n = 1'b1;
    stall = 1'b0; flush = 1'b0;
  endtask

  always @(posedge clk) begin
    #1;
    cyc++;
    if (rst_n && sb.size() > 0) check("capture", act, sb.pop_front());
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    do_reset();
    // LHU
    drive(1, 1, 0, 3'b101, 32'h103, 32'h0, 5'd5, 1, 32'h100, 0, 0);
    // SB then three stall cycles with changing inputs
    drive(1, 0, 1, 3'b000, 32'h200, 32'hA5, 5'd0, 0, 32'h104, 0, 0);
    for (int i = 0; i < 3; i++)
      drive(1, 1, 0, 3'b010, $urandom, $urandom, 5'($urandom), 1, $urandom, 1, 0);
    // stall and flush together with a valid LW
    drive(1, 1, 0, 3'b010, 32'h300, 32'h0, 5'd3, 1, 32'h108, 1, 1);
    // illegal load funct3 011
    drive(1, 1, 0, 3'b011, 32'h304, 32'h0, 5'd4, 1, 32'h10C, 0, 0);
    // load and store both set
    drive(1, 1, 1, 3'b000, 32'h308, 32'h0, 5'd4, 1, 32'h110, 0, 0);
    // five legal loads: 2-bit counter wraps
    for (int i = 0; i < 5; i++)
      drive(1, 1, 0, 3'(i % 3), 32'h400 + i, 32'h0, 5'd9, 1, 32'h200 + 4 * i, 0, 0);
    // bubble and non-memory op
    drive(0, 1, 0, 3'b000, 32'h1, 32'h2, 5'd1, 1, 32'h3, 0, 0);
    drive(1, 0, 0, 3'b111, 32'hDEAD, 32'h2, 5'd2, 1, 32'h4, 0, 0);
    // reset in the middle of a stall
    drive(1, 0, 1, 3'b010, 32'h500, 32'h55, 5'd0, 0, 32'h300, 0, 0);
    drive(1, 1, 0, 3'b000, 32'h504, 32'h0, 5'd1, 1, 32'h304, 1, 0);
    do_reset();

    for (int i = 0; i < 600; i++) begin
      int kind;
      if ($urandom_range(0, 99) == 0) begin
        do_reset();
      end else begin
        kind = $urandom_range(0, 9);
        drive($urandom_range(0, 99) < 85,
              kind < 4 || kind == 9, (kind >= 4 && kind < 7) || kind == 9,
              3'($urandom), $urandom, $urandom, 5'($urandom), 1'($urandom), $urandom,
              $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 8);
      end
    end

    repeat (3) @(negedge clk);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected entries left, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
